// File: rtl/fsm4_pkg.sv
// rtl/fsm4_pkg.sv - shared state encoding and run-length constant for verified_fsm_4
package fsm4_pkg;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_t;

  localparam int MATCH_RUN_LEN = 3;

endpackage

// File: rtl/verified_fsm_4.sv
// rtl/verified_fsm_4.sv - Moore detector of three or more consecutive 1s on a serial input
// FSM4_STATE_OUT_EN: exposes the state register on the STATE port
module verified_fsm_4
  import fsm4_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       IN,
`ifdef FSM4_STATE_OUT_EN
  output logic [1:0] STATE,
`endif
  output logic       MATCH
);

  state_t state_q, state_d;
  logic   match_q, match_d;

  always_comb begin
    state_d = S0;
    case (state_q)
      S0:      state_d = IN ? S1 : S0;
      S1:      state_d = IN ? S2 : S0;
      S2:      state_d = IN ? S3 : S0;
      S3:      state_d = IN ? S3 : S0;
      default: state_d = S0;
    endcase
    // Registered alongside the state, so MATCH never sees IN combinationally
    match_d = (state_d == S3);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
    end
  end

  assign MATCH = match_q;
`ifdef FSM4_STATE_OUT_EN
  assign STATE = state_q;
`endif

endmodule

// File: tb/tb_verified_fsm_4.sv
// tb/tb_verified_fsm_4.sv - directed self-checking bench for verified_fsm_4
module tb_verified_fsm_4;

  logic       CLK;
  logic       RST;
  logic       IN;
  logic       MATCH;
`ifdef FSM4_STATE_OUT_EN
  logic [1:0] STATE;
`endif

  int checks = 0;
  int errors = 0;

  verified_fsm_4 dut (
    .CLK   (CLK),
    .RST   (RST),
    .IN    (IN),
`ifdef FSM4_STATE_OUT_EN
    .STATE (STATE),
`endif
    .MATCH (MATCH)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive rst/in, take one rising edge, then sample 1 time unit later
  task automatic step(input string tag, input logic rst, input logic b,
                      input logic exp_match, input logic [1:0] exp_state);
    RST = rst;
    IN  = b;
    @(posedge CLK);
    #1;
    checks++;
    assert (MATCH === exp_match) else begin
      errors++;
      $error("FAIL %s match: observed %b expected %b", tag, MATCH, exp_match);
    end
`ifdef FSM4_STATE_OUT_EN
    checks++;
    assert (STATE === exp_state) else begin
      errors++;
      $error("FAIL %s state: observed %0d expected %0d", tag, STATE, exp_state);
    end
`else
    if (exp_state > 2'd3) $display("unreachable");
`endif
  endtask

  initial begin
    RST = 1'b1;
    IN  = 1'b0;

    // Reset held three cycles with IN unknown
    step("reset0", 1'b1, 1'bx, 1'b0, 2'd0);
    step("reset1", 1'b1, 1'bx, 1'b0, 2'd0);
    step("reset2", 1'b1, 1'bx, 1'b0, 2'd0);

    // Basic detect: 0,1,1,1
    step("basic_0",  1'b0, 1'b0, 1'b0, 2'd0);
    step("basic_1a", 1'b0, 1'b1, 1'b0, 2'd1);
    step("basic_1b", 1'b0, 1'b1, 1'b0, 2'd2);
    step("basic_1c", 1'b0, 1'b1, 1'b1, 2'd3);

    // Break and re-detect: 0,1,1,1,0,0,0,1,1 then 1,1,1
    step("brk_0",   1'b0, 1'b0, 1'b0, 2'd0);
    step("brk_1a",  1'b0, 1'b1, 1'b0, 2'd1);
    step("brk_1b",  1'b0, 1'b1, 1'b0, 2'd2);
    step("brk_1c",  1'b0, 1'b1, 1'b1, 2'd3);
    step("brk_0a",  1'b0, 1'b0, 1'b0, 2'd0);
    step("brk_0b",  1'b0, 1'b0, 1'b0, 2'd0);
    step("brk_0c",  1'b0, 1'b0, 1'b0, 2'd0);
    step("brk_1d",  1'b0, 1'b1, 1'b0, 2'd1);
    step("brk_1e",  1'b0, 1'b1, 1'b0, 2'd2);
    step("brk_1f",  1'b0, 1'b1, 1'b1, 2'd3);
    step("brk_1g",  1'b0, 1'b1, 1'b1, 2'd3);
    step("brk_1h",  1'b0, 1'b1, 1'b1, 2'd3);

    // Near miss from a clean S0: 1,1,0,1,1,0
    step("near_pre", 1'b0, 1'b0, 1'b0, 2'd0);
    step("near_1a",  1'b0, 1'b1, 1'b0, 2'd1);
    step("near_1b",  1'b0, 1'b1, 1'b0, 2'd2);
    step("near_0a",  1'b0, 1'b0, 1'b0, 2'd0);
    step("near_1c",  1'b0, 1'b1, 1'b0, 2'd1);
    step("near_1d",  1'b0, 1'b1, 1'b0, 2'd2);
    step("near_0b",  1'b0, 1'b0, 1'b0, 2'd0);

    // Saturation: ten 1s
    step("sat_1", 1'b0, 1'b1, 1'b0, 2'd1);
    step("sat_2", 1'b0, 1'b1, 1'b0, 2'd2);
    for (int i = 3; i <= 10; i++) begin
      step($sformatf("sat_%0d", i), 1'b0, 1'b1, 1'b1, 2'd3);
    end

    // Reset from S3 with IN=1, then three more 1s needed
    step("midrst",   1'b1, 1'b1, 1'b0, 2'd0);
    step("midrst_a", 1'b0, 1'b1, 1'b0, 2'd1);
    step("midrst_b", 1'b0, 1'b1, 1'b0, 2'd2);
    step("midrst_c", 1'b0, 1'b1, 1'b1, 2'd3);
    step("midrst_d", 1'b0, 1'b0, 1'b0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
